xor_lane_pipe: RTL and testbench
================================

Name: xor_lane_pipe

Overview:
- Parametrised successor to the single-bit registered XOR.
- Compares two WIDTH-bit operand buses per accepted transaction. Output is the bitwise XOR, the bitwise XNOR, or the reduced parity of the two buses.
- The result passes through a LATENCY-stage valid-qualified pipeline.
- Also tracks mismatch history with a 3-state status FSM and a saturating mismatch counter. The integration benches use these for VCD-assertion checks.

Parameters:
- WIDTH, 4, operand/result width in bits (>=1).
- LATENCY, 2, pipeline stages from accepted input to out (>=1).
- CNT_W, 8, mismatch counter width (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  transaction accepted on a rising clk edge when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  2  0=XOR, 1=XNOR, 2=PARITY, 3=HOLD; sampled with in_valid.
- cnt_clr  input  1  synchronous clear of mismatch_cnt.
- out_valid  output  1  out is valid this cycle.
- out  output  WIDTH  result.
- state  output  2  status FSM: 0=EQ, 1=DIFF, 2=RECOVER.
- mismatch_cnt  output  CNT_W  count of accepted transactions with a!=b (saturating).

Behaviour:
- Reset (rst high at a rising edge), all registers cleared:
  - out_valid=0, out=0, all pipeline stages invalid and zero.
  - state=EQ(0), mismatch_cnt=0, held result register=0.
  - rst overrides in_valid and cnt_clr in the same cycle.
  - Reset mid-operation flushes all in-flight transactions; none emerge afterwards.
- Stage 1 result r, computed from a, b, mode at the accepting edge:
  - XOR: r=a^b.
  - XNOR: r=~(a^b).
  - PARITY: r = {WIDTH-1 zeros, ^(a^b)}.
  - HOLD: r = held result; a and b ignored for r.
- Held result register:
  - Updated with r on every accepted non-HOLD transaction.
  - Not updated on HOLD, so back-to-back HOLDs re-emit the same value.
- Pipeline:
  - Transaction accepted at edge k appears on out with out_valid=1 after edge k+LATENCY-1, i.e. LATENCY cycles after presentation.
  - No backpressure; one transaction per cycle sustained.
  - Bubbles (in_valid=0) propagate: out_valid=0 and out keeps its last value (not zeroed).
- Status FSM:
  - Updates only on accepted transactions, registered, visible one cycle after acceptance; not aligned to out.
  - The comparison a!=b is evaluated in every mode, including HOLD.
  - EQ: a!=b -> DIFF; else stay.
  - DIFF: a==b -> RECOVER; else stay.
  - RECOVER: a==b -> EQ; a!=b -> DIFF.
  - Encoding 3 is unreachable; if entered, go to EQ on the next edge.
- mismatch_cnt:
  - +1 per accepted transaction with a!=b, any mode.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr with a simultaneous counting transaction: result is 1, because clear wins and the same-cycle increment is then applied.
  - cnt_clr alone: result is 0.
- Widths: no arithmetic widening on the datapath; the counter is exactly CNT_W bits.

Decomposition:
- Shared package xor_lane_pkg holds:
  - Mode constants MODE_XOR=2'd0, MODE_XNOR=2'd1, MODE_PARITY=2'd2, MODE_HOLD=2'd3.
  - FSM state constants ST_EQ=2'd0, ST_DIFF=2'd1, ST_RECOVER=2'd2.
- One natural sub-module: xor_lane_delay, a parametrised valid+data shift register of depth LATENCY-1 with synchronous reset.
  - Instantiated after stage 1; degenerates to wires when LATENCY=1.
- FSM and counter stay in the top level.

Test Plan:
All scenarios use WIDTH=4, LATENCY=2, CNT_W=3.
1. Reset: hold rst for 2 cycles with in_valid=1, a=4'hF, b=4'h0 -> out_valid=0, out=0, state=0, mismatch_cnt=0 throughout and one cycle after release.
2. Modes: accept a=4'b1010, b=4'b0110 in XOR, then XNOR, then PARITY on consecutive cycles:
   - out sequence 4'b1100, 4'b0011, 4'b0000, starting 2 cycles after the first accept, with out_valid high for 3 consecutive cycles.
3. FSM walk: accept (a,b) pairs (1,1), (1,0), (3,3), (3,2), (2,2), (2,2):
   - state after each: 0, 1, 2, 1, 2, 0.
   - mismatch_cnt ends at 2.
4. HOLD: accept XOR a=4'h5, b=4'h3, then HOLD twice with a=4'hF, b=4'hF:
   - out = 4'h6, 4'h6, 4'h6.
   - state returns to EQ path (DIFF then RECOVER).
   - mismatch_cnt=1.
5. Saturation and clear:
   - Accept 9 mismatching transactions -> mismatch_cnt sticks at 7.
   - Assert cnt_clr with a mismatching accept -> 1.
   - cnt_clr alone next cycle -> 0.
6. Bubbles and reset flush:
   - Pattern in_valid=1,0,1 -> out_valid 1,0,1 delayed 2 cycles, out unchanged during the bubble.
   - Assert rst one cycle after an accept -> that transaction never appears; out_valid stays 0.

Source files
------------

// File: rtl/xor_lane_pkg.sv
// Shared constants for the XOR lane comparator: operation modes and
// status FSM encodings.
package xor_lane_pkg;

    localparam logic [1:0] MODE_XOR    = 2'd0;
    localparam logic [1:0] MODE_XNOR   = 2'd1;
    localparam logic [1:0] MODE_PARITY = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // ST_ILLEGAL is never entered by design; it names the spare encoding.
    typedef enum logic [1:0] {
        ST_EQ      = 2'd0,
        ST_DIFF    = 2'd1,
        ST_RECOVER = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

endpackage

// File: rtl/xor_lane_delay.sv
// Valid-qualified data shift register of DEPTH stages; data is only
// advanced alongside a valid bit, so bubbles leave the payload untouched.
module xor_lane_delay #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld_r;
    logic [WIDTH-1:0] dat_r [DEPTH];

    // Shift chain: valid always moves, data moves only with a valid token.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                dat_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            vld_r[0] <= in_valid;
            if (in_valid) begin
                dat_r[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end
            end
        end
    end

    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/xor_lane_pipe.sv
// Two-bus XOR/XNOR/parity comparator with a valid-qualified result pipeline,
// a mismatch-history status FSM and a saturating mismatch counter.
module xor_lane_pipe
    import xor_lane_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] r_s;
    logic             ne_s;
    logic [WIDTH-1:0] held_r;
    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_data_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign diff_s = a ^ b;
    assign ne_s   = (a != b);

    // Stage-1 result selection by mode.
    always_comb begin
        r_s = diff_s;
        case (mode)
            MODE_XOR:    r_s = diff_s;
            MODE_XNOR:   r_s = ~diff_s;
            MODE_PARITY: r_s = {{(WIDTH-1){1'b0}}, parity_of(diff_s)} ;
            MODE_HOLD:   r_s = held_r;
            default:     r_s = diff_s;
        endcase
    end

    // Stage-1 register and held result; HOLD re-emits without refreshing.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {WIDTH{1'b0}};
            held_r     <= {WIDTH{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= r_s;
                if (mode != MODE_HOLD) begin
                    held_r <= r_s;
                end
            end
        end
    end

    generate
        if (LATENCY > 1) begin : g_delay
            xor_lane_delay #(
                .WIDTH (WIDTH),
                .DEPTH (LATENCY - 1)
            ) u_delay (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (s1_valid_r),
                .in_data   (s1_data_r),
                .out_valid (out_valid),
                .out_data  (out)
            );
        end else begin : g_nodelay
            assign out_valid = s1_valid_r;
            assign out       = s1_data_r;
        end
    endgenerate

    // Status FSM next state; the spare encoding falls back to EQ unconditionally.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EQ: begin
                if (in_valid && ne_s) begin
                    state_nxt_s = ST_DIFF;
                end else begin
                    state_nxt_s = ST_EQ;
                end
            end
            ST_DIFF: begin
                if (in_valid && !ne_s) begin
                    state_nxt_s = ST_RECOVER;
                end else begin
                    state_nxt_s = ST_DIFF;
                end
            end
            ST_RECOVER: begin
                if (!in_valid) begin
                    state_nxt_s = ST_RECOVER;
                end else if (ne_s) begin
                    state_nxt_s = ST_DIFF;
                end else begin
                    state_nxt_s = ST_EQ;
                end
            end
            default: state_nxt_s = ST_EQ;
        endcase
    end

    // Counter next value: clear first, then apply this cycle's increment.
    always_comb begin
        cnt_base_s = cnt_r;
        cnt_nxt_s  = cnt_r;
        if (cnt_clr) begin
            cnt_base_s = {CNT_W{1'b0}};
        end else begin
            cnt_base_s = cnt_r;
        end
        if (in_valid && ne_s && (cnt_base_s != CNT_MAX)) begin
            cnt_nxt_s = cnt_base_s + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_base_s;
        end
    end

    // Status and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EQ;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign state        = state_r;
    assign mismatch_cnt = cnt_r;

endmodule

// File: tb/tb_xor_lane_pipe.sv
// Randomized and directed self-checking bench for xor_lane_pipe against a
// cycle-history reference model.
module tb_xor_lane_pipe;
    import xor_lane_pkg::*;

    localparam int W   = 4;
    localparam int L   = 2;
    localparam int CW  = 3;
    localparam int MAXE = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a = 4'h0;
    logic [W-1:0]  b = 4'h0;
    logic [1:0]    mode = 2'd0;
    logic          cnt_clr = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out;
    logic [1:0]    state;
    logic [CW-1:0] mismatch_cnt;

    xor_lane_pipe #(.WIDTH(W), .LATENCY(L), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .a            (a),
        .b            (b),
        .mode         (mode),
        .cnt_clr      (cnt_clr),
        .out_valid    (out_valid),
        .out          (out),
        .state        (state),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: history of accepted results per edge.
    bit           acc_h [MAXE];
    logic [W-1:0] res_h [MAXE];
    int           edge_n   = 0;
    int           last_rst = -1;
    logic [W-1:0] m_held   = 4'h0;
    int           m_state  = 0;
    int           m_cnt    = 0;
    bit           m_ov     = 1'b0;
    logic [W-1:0] m_out    = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input logic [1:0] m, input bit clr, input bit r);
        logic [W-1:0] rv;
        bit ne;
        int j;
        if (r) begin
            acc_h[edge_n] = 1'b0;
            res_h[edge_n] = 4'h0;
            last_rst = edge_n;
            m_held = 4'h0; m_state = 0; m_cnt = 0; m_ov = 1'b0; m_out = 4'h0;
        end else begin
            ne = (ta != tb_);
            case (m)
                2'd0:    rv = ta ^ tb_;
                2'd1:    rv = ~(ta ^ tb_);
                2'd2:    rv = ($countones(ta ^ tb_) % 2 == 1) ? 4'h1 : 4'h0;
                default: rv = m_held;
            endcase
            acc_h[edge_n] = v;
            res_h[edge_n] = rv;
            if (v && m != 2'd3) m_held = rv;
            if (v) begin
                if (m_state == 0)      m_state = ne ? 1 : 0;
                else if (m_state == 1) m_state = ne ? 1 : 2;
                else                   m_state = ne ? 1 : 0;
            end
            if (clr) m_cnt = 0;
            if (v && ne && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            j = edge_n - (L - 1);
            m_ov = (j >= 0) && acc_h[j] && (last_rst <= j);
            if (m_ov) m_out = res_h[j];
        end
        edge_n++;
    endtask

    task automatic step(input string tag, input bit v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [1:0] m, input bit clr, input bit r);
        in_valid = v; a = ta; b = tb_; mode = m; cnt_clr = clr; rst = r;
        @(posedge clk);
        model_edge(v, ta, tb_, m, clr, r);
        #1;
        check_eq($sformatf("%s.out_valid@%0d", tag, edge_n), 32'(out_valid), 32'(m_ov));
        check_eq($sformatf("%s.out@%0d", tag, edge_n), 32'(out), 32'(m_out));
        check_eq($sformatf("%s.state@%0d", tag, edge_n), 32'(state), 32'(m_state));
        check_eq($sformatf("%s.cnt@%0d", tag, edge_n), 32'(mismatch_cnt), 32'(m_cnt));
    endtask

    initial begin
        // 1. Reset held for two cycles with an active transaction, then release.
        step("rst", 1'b1, 4'hF, 4'h0, MODE_XOR, 1'b1, 1'b1);
        step("rst", 1'b1, 4'hF, 4'h0, MODE_XOR, 1'b1, 1'b1);
        check_eq("rst_state_const", 32'(state), 32'd0);
        step("rst_rel", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b0);
        check_eq("rst_rel_out_const", 32'(out), 32'd0);

        // 2. Modes back to back.
        step("modes", 1'b1, 4'b1010, 4'b0110, MODE_XOR,    1'b0, 1'b0);
        step("modes", 1'b1, 4'b1010, 4'b0110, MODE_XNOR,   1'b0, 1'b0);
        check_eq("modes_first_out", 32'(out), 32'h0C);
        step("modes", 1'b1, 4'b1010, 4'b0110, MODE_PARITY, 1'b0, 1'b0);
        check_eq("modes_second_out", 32'(out), 32'h03);
        step("modes", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b0);
        check_eq("modes_third_out", 32'(out), 32'h00);
        step("modes", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b0);

        // 3. FSM walk from a clean state.
        step("fsm", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b1);
        step("fsm", 1'b1, 4'd1, 4'd1, MODE_XOR, 1'b0, 1'b0);
        step("fsm", 1'b1, 4'd1, 4'd0, MODE_XOR, 1'b0, 1'b0);
        step("fsm", 1'b1, 4'd3, 4'd3, MODE_XOR, 1'b0, 1'b0);
        check_eq("fsm_recover_const", 32'(state), 32'd2);
        step("fsm", 1'b1, 4'd3, 4'd2, MODE_XOR, 1'b0, 1'b0);
        step("fsm", 1'b1, 4'd2, 4'd2, MODE_XOR, 1'b0, 1'b0);
        step("fsm", 1'b1, 4'd2, 4'd2, MODE_XOR, 1'b0, 1'b0);
        check_eq("fsm_end_cnt_const", 32'(mismatch_cnt), 32'd2);

        // 4. HOLD re-emits the held XOR result.
        step("hold", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b1);
        step("hold", 1'b1, 4'h5, 4'h3, MODE_XOR,  1'b0, 1'b0);
        step("hold", 1'b1, 4'hF, 4'hF, MODE_HOLD, 1'b0, 1'b0);
        step("hold", 1'b1, 4'hF, 4'hF, MODE_HOLD, 1'b0, 1'b0);
        step("hold", 1'b0, 4'h0, 4'h0, MODE_XOR,  1'b0, 1'b0);
        check_eq("hold_out_const", 32'(out), 32'h6);
        check_eq("hold_cnt_const", 32'(mismatch_cnt), 32'd1);

        // 5. Saturation, clear with increment, clear alone.
        step("sat", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step("sat", 1'b1, 4'h1, 4'h2, MODE_XOR, 1'b0, 1'b0);
        check_eq("sat_const", 32'(mismatch_cnt), 32'd7);
        step("sat_clr", 1'b1, 4'h1, 4'h2, MODE_XOR, 1'b1, 1'b0);
        check_eq("clr_inc_const", 32'(mismatch_cnt), 32'd1);
        step("sat_clr", 1'b0, 4'h1, 4'h2, MODE_XOR, 1'b1, 1'b0);
        check_eq("clr_only_const", 32'(mismatch_cnt), 32'd0);

        // 6. Bubble then reset flush of an in-flight transaction.
        step("bub", 1'b1, 4'h9, 4'h3, MODE_XOR, 1'b0, 1'b0);
        step("bub", 1'b0, 4'hF, 4'h0, MODE_XOR, 1'b0, 1'b0);
        step("bub", 1'b1, 4'h7, 4'h1, MODE_XOR, 1'b0, 1'b0);
        step("bub", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b0);
        step("flush", 1'b1, 4'hC, 4'h3, MODE_XOR, 1'b0, 1'b0);
        step("flush", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b1);
        step("flush", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b0);
        check_eq("flush_valid_const", 32'(out_valid), 32'd0);
        step("flush", 1'b0, 4'h0, 4'h0, MODE_XOR, 1'b0, 1'b0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = 4'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? ra : 4'($urandom);
            step("rnd", ($urandom_range(0, 3) != 0), ra, rb, 2'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
